// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: default widths, FSM states
// and the bit positions of the per-field loaded flags.
package alu_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_e;

   localparam int LD_A  = 0;
   localparam int LD_B  = 1;
   localparam int LD_OP = 2;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand bundle from the loader (master) to the downstream adder stage (slave).
interface alu_operand_loader_if #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
);

   // A transfer happens on a rising clock edge where o_valid && i_ready.
   // While o_valid is high the payload is held stable; o_valid never
   // depends on i_ready.
   logic               o_valid;
   logic               i_ready;
   logic [NB_DATA-1:0] o_data_a;
   logic [NB_DATA-1:0] o_data_b;
   logic [NB_OP-1:0]   o_op;
   logic               o_carry;

   modport master (
      output o_valid, o_data_a, o_data_b, o_op, o_carry,
      input  i_ready
   );

   modport slave (
      input  o_valid, o_data_a, o_data_b, o_op, o_carry,
      output i_ready
   );

endinterface

// File: rtl/alu_operand_loader_btn_debouncer.sv
// Level debouncer: the output follows the input only after the input has held
// a new level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts it.
module btn_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_level,
   output logic o_level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (i_level == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         level_d = i_level;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign o_level = level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures operands A/B and opcode+carry from a shared switch bus on button
// presses and presents them as one bundle. Define ALU_LOADER_DEBOUNCE_EN to
// insert a debouncer after each button synchronizer.
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int NB_DATA         = NB_DATA_DEF,
   parameter int NB_OP           = NB_OP_DEF,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NB_DATA-1:0]  i_sw,
   input  logic                i_carry,
   input  logic                i_btn_a,
   input  logic                i_btn_b,
   input  logic                i_btn_op,
   output logic [2:0]          o_loaded,
   output state_e              o_state,
   alu_operand_loader_if.master bus
);

   logic [2:0] btn_raw;
   logic [2:0] sync1_q, sync2_q;
   logic [2:0] level;
   logic [2:0] prev_q;
   logic [1:0] init_q;
   logic [2:0] armed_q;
   logic [2:0] pulse;

   assign btn_raw = {i_btn_op, i_btn_b, i_btn_a};

   // A button only arms once its synchronized level has been seen low after
   // the synchronizer has refilled, so a press held through reset is ignored.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         init_q  <= '0;
         armed_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         prev_q  <= level;
         init_q  <= {init_q[0], 1'b1};
         armed_q <= armed_q | ({3{init_q[1]}} & ~sync2_q);
      end
   end

`ifdef ALU_LOADER_DEBOUNCE_EN
   for (genvar g = 0; g < 3; g++) begin : g_deb
      btn_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_level (sync2_q[g]),
         .o_level (level[g])
      );
   end
`else
   assign level = sync2_q;
`endif

   assign pulse = level & ~prev_q & armed_q;

   state_e             state_q, state_d;
   logic [2:0]         loaded_q, loaded_d;
   logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
   logic [NB_OP-1:0]   op_q, op_d;
   logic               carry_q, carry_d;
   logic [2:0]         cap;

   always_comb begin
      state_d  = state_q;
      loaded_d = loaded_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      carry_d  = carry_q;
      cap      = 3'b000;
      case (state_q)
         COLLECT: begin
            // Once complete the bundle is frozen for its one settling cycle.
            if (loaded_q == 3'b111) begin
               state_d = PRESENT;
            end else begin
               cap      = pulse;
               loaded_d = loaded_q | pulse;
            end
            if (cap[LD_A])  a_d = i_sw;
            if (cap[LD_B])  b_d = i_sw;
            if (cap[LD_OP]) begin
               op_d    = i_sw[NB_OP-1:0];
               carry_d = i_carry;
            end
         end
         PRESENT: begin
            if (bus.i_ready) begin
               loaded_d = 3'b000;
               state_d  = COLLECT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= COLLECT;
         loaded_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         loaded_q <= loaded_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
      end
   end

   assign bus.o_valid  = (state_q == PRESENT);
   assign bus.o_data_a = a_q;
   assign bus.o_data_b = b_q;
   assign bus.o_op     = op_q;
   assign bus.o_carry  = carry_q;
   assign o_loaded     = loaded_q;
   assign o_state      = state_q;

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Sequential front-end stage feeding the 8-bit ALU/carry-lookahead adder datapath. Captures operand A, operand B and opcode (plus carry-in) from a shared switch bus on button presses. Presents them as one registered bundle under a valid/ready handshake, and holds the bundle stable until the downstream adder stage accepts it.

## Interface
- NB_DATA, 8, operand width (matches adder `bits`)
- NB_OP, 6, opcode width (low NB_OP bits of switch bus)
- DEBOUNCE_CYCLES, 16, stable-level cycles required per button (used only with debounce compiled in; must be ≥ 2)

Ports:
- i_clk  in  1  single system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_sw  in  NB_DATA  shared switch data bus
- i_carry  in  1  carry-in switch, captured with opcode
- i_btn_a / i_btn_b / i_btn_op  in  1 each  raw asynchronous load buttons
- i_ready  in  1  downstream accepts bundle
- o_valid  out  1  bundle complete and stable
- o_data_a / o_data_b  out  NB_DATA  captured operands
- o_op  out  NB_OP  captured opcode (i_sw[NB_OP-1:0])
- o_carry  out  1  captured carry-in
- o_loaded  out  3  capture flags {op, b, a}

## Operation
- **Button path:** each button passes a 2-flop synchronizer, then a rising-edge detector (sync & ~prev), giving a 1-cycle load pulse per press. Holding a button yields one pulse only.
- **States:**
  - COLLECT: load pulse A/B/OP captures the relevant i_sw field (OP also captures i_carry) and sets its o_loaded bit.
  - Reloading a field before the bundle is complete overwrites it; the flag stays set.
  - Simultaneous pulses capture all fields from the same i_sw sample.
  - When o_loaded == 3'b111 → PRESENT.
- **PRESENT:**
  - o_valid = 1; all data outputs are frozen.
  - Load pulses are ignored and do not queue.
  - On i_valid&&i_ready (o_valid & i_ready) at a clock edge → clear o_loaded to 0 and go to COLLECT. Data registers keep their last values.
- o_valid depends only on state. It never depends combinationally on i_ready.
- No arithmetic is performed. Fields are truncated as stated; the upper NB_DATA−NB_OP switch bits are ignored for OP.
- **Reset (async assert, sync-release by the system):**
  - state = COLLECT, o_valid = 0, o_loaded = 0.
  - o_data_a = o_data_b = 0, o_op = 0, o_carry = 0.
  - Synchronizer, edge and debounce state = 0.
  - Reset mid-PRESENT drops the bundle. A button held through reset release produces no pulse until it is released and pressed again.

## Timing
- Without debounce: a button high at edge k gives sync output at k+2, the pulse is high during cycle k+2→k+3, and the register updates at edge k+3.
- With debounce: the pulse is delayed a further DEBOUNCE_CYCLES cycles after the synchronized level first differs from the debounced level.
- o_valid rises at the edge after o_loaded becomes 3'b111 (one registered cycle).
- Handshake completes at the edge where o_valid & i_ready. o_valid is low the following cycle, so the minimum bundle period is 2 cycles after the final load.
- A load pulse coincident with the accepting edge is ignored.

## Configuration
- **ALU_LOADER_DEBOUNCE_EN defined:** each synchronized button feeds a debouncer.
  - The output level changes only after the input holds a new level for DEBOUNCE_CYCLES consecutive cycles.
  - The counter restarts on any bounce.
  - The edge detector runs on the debounced level.
- **Undefined:** no debouncer logic and DEBOUNCE_CYCLES is unused. The edge detector runs on the synchronized level (simulation/fast-test build).

## Structure
- Shared package alu_pkg holds:
  - NB_DATA/NB_OP defaults;
  - the state enum typedef (COLLECT, PRESENT);
  - the loaded-flag index constants (LD_A=0, LD_B=1, LD_OP=2).
- One sub-module: btn_debouncer (parameter DEBOUNCE_CYCLES; ports i_clk, i_rst_n, i_level, o_level), instantiated three times under the macro.

## Test plan
- Reset with all buttons low → every output 0, state COLLECT.
- Sequence: i_sw=8'h3C + press A, then i_sw=8'hC5 + press B, then i_sw=8'h02, i_carry=1 + press OP.
  - Required: o_valid rises one cycle after the OP capture.
  - Required outputs: a=8'h3C, b=8'hC5, op=6'h02, carry=1.
- i_ready held low for 10 cycles while pressing A with i_sw=8'hFF.
  - Required: outputs unchanged and o_valid held.
  - Then i_ready=1 for one edge → o_valid=0 and o_loaded=0 the next cycle.
- All three buttons rising in the same cycle with i_sw=8'h81.
  - Required: a=b=8'h81, op=6'h01.
  - Required: o_valid 1 cycle after capture.
- Press A with i_sw=8'h10, then again with 8'h20, then B and OP.
  - Required: bundle a=8'h20.
- Reset asserted while in PRESENT → o_valid drops asynchronously and all outputs are 0.
  - With the debounce build, a 5-cycle glitch on i_btn_b (DEBOUNCE_CYCLES=16) produces no capture.
